// File: rtl/instr_issuer.sv
// Instruction source for the datapath core: loadable program store, PC and a
// valid/done issue handshake. JMP/BRZ/HALT are resolved here; a watchdog guards done.
module instr_issuer #(
  parameter int IW      = 10,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          z_flag,
  input  logic          done,
  output logic [IW-1:0] instruction,
  output logic          instr_valid,
  output logic          busy,
  output logic          halted,
  output logic          timeout_err,
  output logic [AW-1:0] pc,
  output logic [15:0]   issued_cnt
);

  localparam int DEPTH = 2 ** AW;
  localparam int WW    = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_HALT = 3'b101;
  localparam logic [2:0] OP_BRZ  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t state_reg, state_next;

  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] instr_q;

  logic [AW-1:0] pc_reg, pc_next;
  logic [IW-1:0] instr_reg, instr_next;
  logic          valid_reg, valid_next;
  logic          terr_reg, terr_next;
  logic [15:0]   cnt_reg, cnt_next;
  logic [WW-1:0] wdog_reg, wdog_next;

  logic          accept_cmd;
  logic [2:0]    opcode;
  logic [AW-1:0] target;

  assign accept_cmd = (state_reg == S_IDLE) || (state_reg == S_HALTED);
  assign opcode     = instr_q[IW-1:IW-3];
  assign target     = instr_q[AW-1:0];

  // Program store: writes only while stopped, so a running program is never disturbed.
  always_ff @(posedge clk) begin
    if (accept_cmd && load_en) begin
      mem[load_addr] <= load_data;
    end
    if (state_reg == S_FETCH) begin
      instr_q <= mem[pc_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      instr_reg <= '0;
      valid_reg <= 1'b0;
      terr_reg  <= 1'b0;
      cnt_reg   <= '0;
      wdog_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
      terr_reg  <= terr_next;
      cnt_reg   <= cnt_next;
      wdog_reg  <= wdog_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    terr_next  = terr_reg;
    cnt_next   = cnt_reg;
    wdog_next  = wdog_reg;
    case (state_reg)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_next    = '0;
          cnt_next   = '0;
          terr_next  = 1'b0;
          state_next = S_FETCH;
        end
      end
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_HALT: state_next = S_HALTED;
          OP_JMP: begin
            pc_next    = target;
            state_next = S_FETCH;
          end
          OP_BRZ: begin
            pc_next    = z_flag ? target : pc_reg + AW'(1);
            state_next = S_FETCH;
          end
          default: begin
            instr_next = instr_q;
            valid_next = 1'b1;
            wdog_next  = '0;
            state_next = S_ISSUE;
          end
        endcase
      end
      S_ISSUE: begin
        // done wins over a watchdog expiring in the same cycle
        if (done) begin
          valid_next = 1'b0;
          pc_next    = pc_reg + AW'(1);
          if (cnt_reg != 16'hFFFF) begin
            cnt_next = cnt_reg + 16'd1;
          end
          state_next = S_FETCH;
        end else if (wdog_reg == WW'(TIMEOUT - 1)) begin
          terr_next  = 1'b1;
          valid_next = 1'b0;
          state_next = S_HALTED;
        end else begin
          wdog_next = wdog_reg + WW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign instruction = instr_reg;
  assign instr_valid = valid_reg;
  assign busy        = (state_reg == S_FETCH) || (state_reg == S_DECODE) || (state_reg == S_ISSUE);
  assign halted      = (state_reg == S_HALTED);
  assign timeout_err = terr_reg;
  assign pc          = pc_reg;
  assign issued_cnt  = cnt_reg;

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: expected issue stream kept in a queue and
// popped as the DUT presents each instruction.
module tb_instr_issuer;

  localparam int IW = 10;
  localparam int AW = 4;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic          z_flag = 1'b0;
  logic          done = 1'b0;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic          busy;
  logic          halted;
  logic          timeout_err;
  logic [AW-1:0] pc;
  logic [15:0]   issued_cnt;

  int errors = 0;
  int checks = 0;
  logic [IW-1:0] exp_q[$];
  logic [AW-1:0] pcd_q[$];

  instr_issuer #(.IW(IW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .z_flag(z_flag), .done(done),
    .instruction(instruction), .instr_valid(instr_valid), .busy(busy),
    .halted(halted), .timeout_err(timeout_err), .pc(pc), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 20) begin tick(); n++; end
    checks++;
    if (!instr_valid) begin
      errors++;
      $display("FAIL %s_wait_valid: instr_valid=%0b required 1", tag, instr_valid);
    end
  endtask

  // Runs until HALTED, answering each presented instruction with done after ddly cycles.
  task automatic run_prog(input string tag, input int ddly, input logic z_first, input logic z_rest);
    int n = 0;
    logic [IW-1:0] e;
    pcd_q.delete();
    z_flag = z_first;
    while (!halted && n < 500) begin
      if (instr_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_unexpected: got %h required none", tag, instruction);
        end else begin
          e = exp_q.pop_front();
          if (instruction !== e) begin
            errors++;
            $display("FAIL %s_issue: got %h required %h", tag, instruction, e);
          end
        end
        repeat (ddly) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        pcd_q.push_back(pc);
        z_flag = z_rest;
        n += ddly + 1;
      end else begin
        tick();
        n++;
      end
    end
    checks++;
    if (!halted) begin
      errors++;
      $display("FAIL %s_halt_bound: halted=%0b required 1", tag, halted);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d expected instructions never issued", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, halted, instr_valid, timeout_err} !== 4'b0000 || pc !== '0 ||
        issued_cnt !== 16'd0 || instruction !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b halted=%0b valid=%0b terr=%0b pc=%0d cnt=%0d instr=%h required all 0",
               busy, halted, instr_valid, timeout_err, pc, issued_cnt, instruction);
    end
    load(0, 10'h041); load(1, 10'h082); load(2, 10'h280);
    pulse_start();
    wait_valid("reset");
    rst = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || pc !== '0 || busy !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: valid=%0b pc=%0d busy=%0b halted=%0b required 0 0 0 0",
               instr_valid, pc, busy, halted);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || issued_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b cnt=%0d required 0 0", busy, issued_cnt);
    end
  endtask

  task automatic test_linear();
    load(0, 10'h041); load(1, 10'h082); load(2, 10'h280);
    exp_q.push_back(10'h041); exp_q.push_back(10'h082);
    pulse_start();
    run_prog("linear", 3, 1'b0, 1'b0);
    checks++;
    if (pc !== 4'd2 || issued_cnt !== 16'd2 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL linear_final: pc=%0d cnt=%0d terr=%0b required 2 2 0", pc, issued_cnt, timeout_err);
    end
  endtask

  task automatic test_branch();
    load(0, 10'h304); load(1, 10'h011); load(2, 10'h280);
    load(4, 10'h022); load(5, 10'h280);
    exp_q.push_back(10'h022);
    pulse_start();
    run_prog("brz_taken", 1, 1'b1, 1'b1);
    checks++;
    if (pc !== 4'd5 || issued_cnt !== 16'd1) begin
      errors++;
      $display("FAIL brz_taken_final: pc=%0d cnt=%0d required 5 1", pc, issued_cnt);
    end
    exp_q.push_back(10'h011);
    pulse_start();
    run_prog("brz_untaken", 2, 1'b0, 1'b0);
    checks++;
    if (pc !== 4'd2 || issued_cnt !== 16'd1) begin
      errors++;
      $display("FAIL brz_untaken_final: pc=%0d cnt=%0d required 2 1", pc, issued_cnt);
    end
  endtask

  task automatic test_jmp_wrap();
    load(0, 10'h30F); load(1, 10'h3C3); load(3, 10'h033);
    load(4, 10'h280); load(15, 10'h055);
    exp_q.push_back(10'h055); exp_q.push_back(10'h033);
    pulse_start();
    run_prog("jmp_wrap", 3, 1'b1, 1'b0);
    checks++;
    if (pcd_q.size() != 2) begin
      errors++;
      $display("FAIL jmp_wrap_dones: got %0d done pcs required 2", pcd_q.size());
    end else begin
      if (pcd_q[0] !== 4'd0) begin
        errors++;
        $display("FAIL jmp_wrap_pc: pc after done at 15 = %0d required 0", pcd_q[0]);
      end
      checks++;
      if (pcd_q[1] !== 4'd4) begin
        errors++;
        $display("FAIL jmp_target_pc: pc after done at 3 = %0d required 4", pcd_q[1]);
      end
    end
    checks++;
    if (pc !== 4'd4 || issued_cnt !== 16'd2) begin
      errors++;
      $display("FAIL jmp_final: pc=%0d cnt=%0d required 4 2", pc, issued_cnt);
    end
  endtask

  task automatic test_watchdog();
    int cnt = 0;
    load(0, 10'h041);
    pulse_start();
    wait_valid("wdog");
    while (!halted && cnt < 200) begin tick(); cnt++; end
    checks++;
    if (cnt != TIMEOUT) begin
      errors++;
      $display("FAIL wdog_latency: halted after %0d cycles required %0d", cnt, TIMEOUT);
    end
    checks++;
    if (timeout_err !== 1'b1 || instr_valid !== 1'b0 || issued_cnt !== 16'd0) begin
      errors++;
      $display("FAIL wdog_flags: terr=%0b valid=%0b cnt=%0d required 1 0 0", timeout_err, instr_valid, issued_cnt);
    end
    // load and start together: the new word must be the one fetched
    load_en = 1'b1; load_addr = 4'd0; load_data = 10'h280; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wdog_clear: terr=%0b busy=%0b required 0 1", timeout_err, busy);
    end
    repeat (2) tick();
    checks++;
    if (halted !== 1'b1 || pc !== 4'd0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_start_same: halted=%0b pc=%0d valid=%0b required 1 0 0", halted, pc, instr_valid);
    end
  endtask

  task automatic test_ignore();
    int n = 0;
    load(0, 10'h041); load(1, 10'h280);
    pulse_start();
    wait_valid("ignore");
    load_en = 1'b1; load_addr = 4'd0; load_data = 10'h3C0; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || pc !== 4'd0 || instruction !== 10'h041) begin
      errors++;
      $display("FAIL busy_cmds: valid=%0b pc=%0d instr=%h required 1 0 041", instr_valid, pc, instruction);
    end
    done = 1'b1; tick(); done = 1'b0;
    while (!halted && n < 20) begin tick(); n++; end
    exp_q.push_back(10'h041);
    pulse_start();
    run_prog("ignore_rerun", 1, 1'b0, 1'b0);
    checks++;
    if (pc !== 4'd1 || issued_cnt !== 16'd1) begin
      errors++;
      $display("FAIL ignore_rerun_final: pc=%0d cnt=%0d required 1 1", pc, issued_cnt);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    done = 1'b1; repeat (3) tick(); done = 1'b0;
    tick();
    checks++;
    if (issued_cnt !== 16'd0 || busy !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL done_idle: cnt=%0d busy=%0b halted=%0b required 0 0 0", issued_cnt, busy, halted);
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_branch();
    test_jmp_wrap();
    test_watchdog();
    test_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
